// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider bank.
//   CNT_W_DEF : default half-period counter width
//   CNT_W_MAX : widest counter the config struct can carry (CNT_W must not exceed it)
//   ch_cfg_t  : per-channel config payload (half period, plus phase when
//               CLK_DIV_BANK_PHASE_EN is defined)
//   def_half  : reset half period for channel idx, 2^idx saturated to w bits
package clk_div_pkg;

   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned CNT_W_MAX = 32;

   typedef struct packed {
      logic [CNT_W_MAX-1:0] half;
`ifdef CLK_DIV_BANK_PHASE_EN
      logic [CNT_W_MAX-1:0] phase;
`endif
   } ch_cfg_t;

   // A shift by CNT_W_MAX wraps to 0, so the subtraction yields all ones.
   function automatic logic [CNT_W_MAX-1:0] def_half(input int unsigned idx,
                                                     input int unsigned w);
      return (idx >= w) ? ((CNT_W_MAX'(1) << w) - CNT_W_MAX'(1))
                        : (CNT_W_MAX'(1) << idx);
   endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Config port of the clock-divider bank (valid/ready).
//   cfg_valid : request from master
//   cfg_ready : slot free, driven by the bank
//   cfg_ch    : target channel
//   cfg_half  : new half period in clk cycles, 0 switches the channel off
//   cfg_phase : start count used at sync (only with CLK_DIV_BANK_PHASE_EN)
interface clk_div_bank_if
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned CNT_W  = CNT_W_DEF
) ();

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_half;
`ifdef CLK_DIV_BANK_PHASE_EN
   logic [CNT_W-1:0] cfg_phase;

   modport master (output cfg_valid, cfg_ch, cfg_half, cfg_phase, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_half, cfg_phase, output cfg_ready);
`else
   modport master (output cfg_valid, cfg_ch, cfg_half, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_half, output cfg_ready);
`endif

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, square-wave output, rising-edge
// tick, and a pending-update register applied only at a 1->0 boundary so no
// high or low time is ever cut short.
// Optional feature macro: CLK_DIV_BANK_PHASE_EN (start count applied at sync).
//   clk, rst    : system clock, synchronous active-high reset
//   sync_i      : realign pulse
//   ld_i        : accept a new config for this channel
//   cfg_half_i  : new half period (0 = off)
//   cfg_phase_i : new start phase (feature builds only)
//   clk_out_o   : divided clock
//   tick_o      : one-cycle pulse with each clk_out_o 0->1
//   pend_d_c    : next-cycle value of the pending flag (combinational)
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned      CNT_W = CNT_W_DEF,
   parameter logic [CNT_W-1:0] H_RST = CNT_W'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync_i,
   input  logic             ld_i,
   input  logic [CNT_W-1:0] cfg_half_i,
`ifdef CLK_DIV_BANK_PHASE_EN
   input  logic [CNT_W-1:0] cfg_phase_i,
`endif
   output logic             clk_out_o,
   output logic             tick_o,
   output logic             pend_d_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             tick_q, tick_d;
   logic             p_q, p_d;
   ch_cfg_t          hp_q, hp_d;
`ifdef CLK_DIV_BANK_PHASE_EN
   logic [CNT_W-1:0] ph_q, ph_d;
   logic [CNT_W-1:0] ph_sel;
   logic [CNT_W-1:0] h_sel;
`endif
   logic [CNT_W-1:0] h_new;
   logic [CNT_W-1:0] start_cnt;
   logic             at_end;

   // Narrow a stored payload field back to counter width.
   function automatic logic [CNT_W-1:0] fit(input logic [CNT_W_MAX-1:0] x);
      return (x > CNT_W_MAX'(CNT_MAX)) ? CNT_MAX : x[CNT_W-1:0];
   endfunction

   // Counter start value after sync, using the post-apply half/phase.
   always_comb begin
      h_new     = fit(hp_q.half);
      at_end    = (h_q != '0) && (cnt_q == h_q - CNT_W'(1));
      start_cnt = '0;
`ifdef CLK_DIV_BANK_PHASE_EN
      h_sel  = p_q ? h_new : h_q;
      ph_sel = p_q ? fit(hp_q.phase) : ph_q;
      if (h_sel != '0) begin
         start_cnt = (ph_sel > h_sel - CNT_W'(1)) ? (h_sel - CNT_W'(1)) : ph_sel;
      end
`endif
   end

   // Next-state: sync > disabled channel > end of half period > count.
   always_comb begin
      h_d    = h_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      tick_d = 1'b0;
      p_d    = p_q;
      hp_d   = hp_q;
`ifdef CLK_DIV_BANK_PHASE_EN
      ph_d   = ph_q;
`endif
      if (sync_i) begin
         if (p_q) begin
            h_d = h_new;
`ifdef CLK_DIV_BANK_PHASE_EN
            ph_d = fit(hp_q.phase);
`endif
            p_d = 1'b0;
         end
         cnt_d = start_cnt;
         out_d = 1'b0;
      end else if (h_q == '0) begin
         cnt_d = '0;
         out_d = 1'b0;
         if (p_q) begin
            h_d = h_new;
`ifdef CLK_DIV_BANK_PHASE_EN
            ph_d = fit(hp_q.phase);
`endif
            p_d = 1'b0;
         end
      end else if (at_end) begin
         tick_d = ~out_q;
         cnt_d  = '0;
         if (out_q && p_q) begin
            out_d = 1'b0;
            h_d   = h_new;
`ifdef CLK_DIV_BANK_PHASE_EN
            ph_d  = fit(hp_q.phase);
`endif
            p_d   = 1'b0;
         end else begin
            out_d = ~out_q;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // A same-cycle acceptance survives a sync-time apply.
      if (ld_i) begin
         p_d       = 1'b1;
         hp_d.half = CNT_W_MAX'(cfg_half_i);
`ifdef CLK_DIV_BANK_PHASE_EN
         hp_d.phase = CNT_W_MAX'(cfg_phase_i);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q    <= H_RST;
         cnt_q  <= '0;
         out_q  <= 1'b0;
         tick_q <= 1'b0;
         p_q    <= 1'b0;
         hp_q   <= '0;
`ifdef CLK_DIV_BANK_PHASE_EN
         ph_q   <= '0;
`endif
      end else begin
         h_q    <= h_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         tick_q <= tick_d;
         p_q    <= p_d;
         hp_q   <= hp_d;
`ifdef CLK_DIV_BANK_PHASE_EN
         ph_q   <= ph_d;
`endif
      end
   end

   assign clk_out_o = out_q;
   assign tick_o    = tick_q;
   assign pend_d_c  = p_d;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel clock-divider bank: NUM_CH divided square waves with
// rising-edge ticks, run-time reprogrammable through a valid/ready port.
// Optional feature macro: CLK_DIV_BANK_PHASE_EN (per-channel sync phase).
//   clk, rst : system clock, synchronous active-high reset
//   sync     : one-cycle realign pulse for all channels
//   cfg      : config port (slave side of clk_div_bank_if)
//   clk_out  : divided clocks
//   tick     : one-cycle pulse with each clk_out 0->1
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sync,
   clk_div_bank_if.slave     cfg,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              cfg_ready_q, cfg_ready_d;
   logic              accept;
   logic              ch_ok;
   logic [NUM_CH-1:0] ld;
   logic [NUM_CH-1:0] pend_d;

   // Out-of-range channels are accepted and dropped.
   always_comb begin
      accept = cfg.cfg_valid && cfg_ready_q;
      ch_ok  = 32'(cfg.cfg_ch) < NUM_CH;
      ld     = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ld[i] = accept && ch_ok && (cfg.cfg_ch == CH_W'(i));
      end
   end

   // Slot is free once no channel will hold a pending update.
   always_comb begin
      cfg_ready_d = ~|pend_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_ready_q <= 1'b1;
      end else begin
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg.cfg_ready = cfg_ready_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_ch #(
         .CNT_W (CNT_W),
         .H_RST (CNT_W'(def_half(32'(i), CNT_W)))
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .sync_i      (sync),
         .ld_i        (ld[i]),
         .cfg_half_i  (cfg.cfg_half),
`ifdef CLK_DIV_BANK_PHASE_EN
         .cfg_phase_i (cfg.cfg_phase),
`endif
         .clk_out_o   (clk_out[i]),
         .tick_o      (tick[i]),
         .pend_d_c    (pend_d[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       sync;
   logic [2:0] clk_out;
   logic [2:0] tick;

   int n_cmp = 0;
   int n_err = 0;

   clk_div_bank_if #(.NUM_CH(3), .CNT_W(16)) cfg_if ();

   clk_div_bank #(.NUM_CH(3), .CNT_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .sync    (sync),
      .cfg     (cfg_if.slave),
      .clk_out (clk_out),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        sync;
      logic        vld;
      logic [1:0]  ch;
      logic [15:0] half;
      logic [2:0]  exp_out;
      logic [2:0]  exp_tick;
      logic        exp_rdy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic s, input logic v, input logic [1:0] c,
                      input logic [15:0] h, input logic [2:0] eo, input logic [2:0] et,
                      input logic er);
      vec_t x;
      x.rst = r; x.sync = s; x.vld = v; x.ch = c; x.half = h;
      x.exp_out = eo; x.exp_tick = et; x.exp_rdy = er;
      vecs.push_back(x);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic v, input logic [1:0] c,
                        input logic [15:0] h, input logic [15:0] ph);
      rst              = r;
      sync             = s;
      cfg_if.cfg_valid = v;
      cfg_if.cfg_ch    = c;
      cfg_if.cfg_half  = h;
`ifdef CLK_DIV_BANK_PHASE_EN
      cfg_if.cfg_phase = ph;
`else
      if (ph != 16'd0) $display("note: phase ignored in this build");
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic b1 [48];
      logic rd [48];
      int   rises [$];
      int   run, min_run, first_run, low_cnt, wt;
      int   t0, t1, t2, hi2;
      bit   found;

      drive(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
      step();
      step();

      // Reset defaults
      add(1,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b001,3'b001,1);
      add(0,0,0,0,0, 3'b010,3'b010,1);
      add(0,0,0,0,0, 3'b011,3'b001,1);
      add(0,0,0,0,0, 3'b100,3'b100,1);
      add(0,0,0,0,0, 3'b101,3'b001,1);
      add(0,0,0,0,0, 3'b110,3'b010,1);
      add(0,0,0,0,0, 3'b111,3'b001,1);
      add(0,0,0,0,0, 3'b000,3'b000,1);
      // ch1 -> H=3 during its high phase
      add(1,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b001,3'b001,1);
      add(0,0,0,0,0, 3'b010,3'b010,1);
      add(0,0,1,1,3, 3'b011,3'b001,0);
      add(0,0,0,0,0, 3'b100,3'b100,1);
      add(0,0,0,0,0, 3'b101,3'b001,1);
      add(0,0,0,0,0, 3'b100,3'b000,1);
      add(0,0,0,0,0, 3'b111,3'b011,1);
      add(0,0,0,0,0, 3'b010,3'b000,1);
      add(0,0,0,0,0, 3'b011,3'b001,1);
      add(0,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b001,3'b001,1);
      add(0,0,0,0,0, 3'b100,3'b100,1);
      add(0,0,0,0,0, 3'b111,3'b011,1);
      // ch2 off, then H=5
      add(1,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,1,2,0, 3'b001,3'b001,0);
      add(0,0,0,0,0, 3'b010,3'b010,0);
      add(0,0,0,0,0, 3'b011,3'b001,0);
      add(0,0,0,0,0, 3'b100,3'b100,0);
      add(0,0,0,0,0, 3'b101,3'b001,0);
      add(0,0,0,0,0, 3'b110,3'b010,0);
      add(0,0,0,0,0, 3'b111,3'b001,0);
      add(0,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,1,2,5, 3'b001,3'b001,0);
      add(0,0,0,0,0, 3'b010,3'b010,1);
      add(0,0,0,0,0, 3'b011,3'b001,1);
      add(0,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b001,3'b001,1);
      add(0,0,0,0,0, 3'b010,3'b010,1);
      add(0,0,0,0,0, 3'b111,3'b101,1);
      add(0,0,0,0,0, 3'b100,3'b000,1);
      // Out-of-range channel
      add(1,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,1,3,7, 3'b001,3'b001,1);
      add(0,0,0,0,0, 3'b010,3'b010,1);
      add(0,0,0,0,0, 3'b011,3'b001,1);
      add(0,0,0,0,0, 3'b100,3'b100,1);
      // Sync while ch0 H=4 is pending
      add(1,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b001,3'b001,1);
      add(0,0,1,0,4, 3'b010,3'b010,0);
      add(0,1,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b010,3'b010,1);
      add(0,0,0,0,0, 3'b010,3'b000,1);
      add(0,0,0,0,0, 3'b101,3'b101,1);
      add(0,0,0,0,0, 3'b101,3'b000,1);
      add(0,0,0,0,0, 3'b111,3'b010,1);
      add(0,0,0,0,0, 3'b111,3'b000,1);
      add(0,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b010,3'b010,1);
      add(0,0,0,0,0, 3'b010,3'b000,1);
      add(0,0,0,0,0, 3'b101,3'b101,1);
      // Reset with ch1 H=7 pending
      add(1,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,1,1,7, 3'b001,3'b001,0);
      add(0,0,0,0,0, 3'b010,3'b010,0);
      add(1,0,0,0,0, 3'b000,3'b000,1);
      add(0,0,0,0,0, 3'b001,3'b001,1);
      add(0,0,0,0,0, 3'b010,3'b010,1);
      add(0,0,0,0,0, 3'b011,3'b001,1);
      add(0,0,0,0,0, 3'b100,3'b100,1);
      add(0,0,0,0,0, 3'b101,3'b001,1);
      add(0,0,0,0,0, 3'b110,3'b010,1);

      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k].rst, vecs[k].sync, vecs[k].vld, vecs[k].ch, vecs[k].half, 16'd0);
         step();
         check($sformatf("row%0d clk_out", k), 32'(clk_out), 32'(vecs[k].exp_out));
         check($sformatf("row%0d tick", k), 32'(tick), 32'(vecs[k].exp_tick));
         check($sformatf("row%0d cfg_ready", k), 32'(cfg_if.cfg_ready), 32'(vecs[k].exp_rdy));
      end

      // Tick and high-time counts over 64 cycles from reset
      drive(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
      step();
      drive(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
      t0 = 0; t1 = 0; t2 = 0; hi2 = 0;
      for (int c = 0; c < 64; c++) begin
         step();
         t0 += int'(tick[0]);
         t1 += int'(tick[1]);
         t2 += int'(tick[2]);
         hi2 += int'(clk_out[2]);
      end
      check("tick0 count", 32'(t0), 32'd32);
      check("tick1 count", 32'(t1), 32'd16);
      check("tick2 count", 32'(t2), 32'd8);
      check("clk_out2 high cycles", 32'(hi2), 32'd32);

      // Reprogram ch1 to H=3 just after a rise; check pulse widths and period
      drive(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
      step();
      drive(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
         step();
         if (clk_out[1]) found = 1'b1;
      end
      check("ch1 rise seen", 32'(found), 32'd1);
      b1[0] = clk_out[1];
      rd[0] = cfg_if.cfg_ready;
      drive(1'b0, 1'b0, 1'b1, 2'd1, 16'd3, 16'd0);
      for (int c = 1; c < 48; c++) begin
         step();
         drive(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
         b1[c] = clk_out[1];
         rd[c] = cfg_if.cfg_ready;
      end
      run = 1; min_run = 1000; first_run = -1; low_cnt = 0;
      for (int c = 1; c < 48; c++) begin
         if (!rd[c]) low_cnt++;
         if (b1[c] == b1[c-1]) begin
            run++;
         end else begin
            if (first_run < 0) first_run = run;
            else if (run < min_run) min_run = run;
            run = 1;
            if (b1[c]) rises.push_back(c);
         end
      end
      check("ch1 first high run", 32'(first_run), 32'd2);
      check("ch1 min pulse >= 2", 32'(min_run >= 2), 32'd1);
      check("cfg_ready low cycles", 32'(low_cnt), 32'd1);
      check("cfg_ready low after accept", 32'(rd[1]), 32'd0);
      check("ch1 rise count", 32'(rises.size() >= 3), 32'd1);
      if (rises.size() >= 3) begin
         check("ch1 period a", 32'(rises[1] - rises[0]), 32'd6);
         check("ch1 period b", 32'(rises[2] - rises[1]), 32'd6);
      end

      // ch2 H=4 (phase 2 when enabled) then sync: first rise delay
      drive(1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
      step();
      drive(1'b0, 1'b0, 1'b1, 2'd2, 16'd4, 16'd2);
      step();
      drive(1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 16'd0);
      step();
      drive(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0);
      check("sync clk_out", 32'(clk_out), 32'd0);
      check("sync cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
      found = 1'b0;
      wt = 0;
      for (int c = 1; c <= 10 && !found; c++) begin
         step();
         if (clk_out[2]) begin
            found = 1'b1;
            wt = c;
         end
      end
      check("ch2 rise after sync seen", 32'(found), 32'd1);
`ifdef CLK_DIV_BANK_PHASE_EN
      check("ch2 phase rise delay", 32'(wt), 32'd2);
`else
      check("ch2 rise delay", 32'(wt), 32'd4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
